// File: rtl/exe_md_stage.sv
// Execute stage with an iterative multiply/divide unit and architectural HI/LO registers.
// Define MD_FAST_MUL_EN for a single-cycle registered multiplier; DIV stays iterative.
module exe_md_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RF_AW = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             allow_in,
  input  logic [2:0]       in_op,
  input  logic             in_sel_lo,
  input  logic [XLEN-1:0]  in_src_a,
  input  logic [XLEN-1:0]  in_src_b,
  input  logic [RF_AW-1:0] in_rd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             next_allow_in,
  output logic [XLEN-1:0]  out_data,
  output logic [RF_AW-1:0] out_rd,
  output logic             out_wen,
  output logic             busy,
  output logic [XLEN-1:0]  hi,
  output logic [XLEN-1:0]  lo
);

  localparam int unsigned CW = $clog2(XLEN);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;
  localparam logic [2:0] OpMf    = 3'd7;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e             state_q, state_d;
  logic               valid_q, valid_d;
  logic [2:0]         op_q, op_d;
  logic               sel_lo_q, sel_lo_d;
  logic [XLEN-1:0]    a_q, a_d, b_q, b_d;
  logic [RF_AW-1:0]   rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]    hi_q, hi_d, lo_q, lo_d;

  logic               is_mul, is_div, is_signed, sa, sb;
  logic               ready_go, handoff, accept, last;
  logic [XLEN-1:0]    mag_a, mag_b;
  logic [XLEN:0]      mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0]  mul_next, mul_fix, div_next;
  logic               div_ge;
  logic [XLEN-1:0]    div_q_mag, div_r_mag;
`ifdef MD_FAST_MUL_EN
  logic [2*XLEN-1:0]  fast_prod, fast_fix;
`endif

  always_comb begin
    is_mul    = (op_q == OpMult) || (op_q == OpMultu);
    is_div    = (op_q == OpDiv) || (op_q == OpDivu);
    is_signed = (op_q == OpMult) || (op_q == OpDiv);
    sa        = is_signed & a_q[XLEN-1];
    sb        = is_signed & b_q[XLEN-1];
    mag_a     = sa ? -a_q : a_q;
    mag_b     = sb ? -b_q : b_q;
    ready_go  = (state_q == StDone) || ((state_q == StIdle) && !is_mul && !is_div);
    handoff   = valid_q & ready_go & next_allow_in;
    allow_in  = ~valid_q | (ready_go & next_allow_in);
    accept    = in_valid & allow_in & ~flush;
    last      = (cnt_q == CW'(XLEN - 1));

    // Shift-add: acc holds {partial product, unconsumed multiplier bits}.
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    mul_fix   = (sa ^ sb) ? -mul_next : mul_next;

    // Restoring divide: acc holds {partial remainder, dividend/quotient shift register}.
    div_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_sh - {1'b0, mag_b};
    div_ge    = ~div_diff[XLEN];
    div_r_mag = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
    div_q_mag = {acc_q[XLEN-2:0], div_ge};
    div_next  = {div_r_mag, div_q_mag};
`ifdef MD_FAST_MUL_EN
    fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    fast_fix  = (sa ^ sb) ? -fast_prod : fast_prod;
`endif
  end

  always_comb begin
    valid_d  = valid_q & ~handoff;
    op_d     = op_q;
    sel_lo_d = sel_lo_q;
    a_d      = a_q;
    b_d      = b_q;
    rd_d     = rd_q;
    if (accept) begin
      valid_d  = 1'b1;
      op_d     = in_op;
      sel_lo_d = in_sel_lo;
      a_d      = in_src_a;
      b_d      = in_src_b;
      rd_d     = in_rd;
    end
    if (flush) valid_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (valid_q) begin
          if (is_mul) begin
`ifdef MD_FAST_MUL_EN
            {hi_d, lo_d} = fast_fix;
            state_d      = StDone;
`else
            acc_d   = {{XLEN{1'b0}}, mag_b};
            cnt_d   = '0;
            state_d = StMul;
`endif
          end else if (is_div) begin
            acc_d   = {{XLEN{1'b0}}, mag_a};
            cnt_d   = '0;
            state_d = StDiv;
          end else if (op_q == OpMthi) begin
            hi_d = a_q;
          end else if (op_q == OpMtlo) begin
            lo_d = a_q;
          end
        end
      end
      StMul: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          {hi_d, lo_d} = mul_fix;
          cnt_d        = '0;
          state_d      = StDone;
        end
      end
      StDiv: begin
        acc_d = div_next;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          if (b_q == '0) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = (sa ^ sb) ? -div_q_mag : div_q_mag;
            hi_d = sa ? -div_r_mag : div_r_mag;
          end
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (handoff) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      valid_q  <= 1'b0;
      op_q     <= '0;
      sel_lo_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      op_q     <= op_d;
      sel_lo_q <= sel_lo_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign out_valid = valid_q & ready_go;
  assign out_data  = (valid_q && op_q == OpMf) ? (sel_lo_q ? lo_q : hi_q) : '0;
  assign out_rd    = rd_q;
  assign out_wen   = valid_q & (op_q == OpMf);
  assign busy      = (state_q != StIdle);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_exe_md_stage.sv
// Scoreboard bench for exe_md_stage: a reference HI/LO model predicts each handoff.
module tb_exe_md_stage;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned RF_AW = 5;
`ifdef MD_FAST_MUL_EN
  localparam int MulLat = 2;
`else
  localparam int MulLat = XLEN + 2;
`endif

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             in_valid = 1'b0;
  logic [2:0]       in_op = '0;
  logic             in_sel_lo = 1'b0;
  logic [XLEN-1:0]  in_src_a = '0;
  logic [XLEN-1:0]  in_src_b = '0;
  logic [RF_AW-1:0] in_rd = '0;
  logic             flush = 1'b0;
  logic             next_allow_in = 1'b1;
  logic             allow_in, out_valid, out_wen, busy;
  logic [XLEN-1:0]  out_data, hi, lo;
  logic [RF_AW-1:0] out_rd;

  exe_md_stage #(.XLEN(XLEN), .RF_AW(RF_AW)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .allow_in(allow_in), .in_op(in_op),
    .in_sel_lo(in_sel_lo), .in_src_a(in_src_a), .in_src_b(in_src_b), .in_rd(in_rd),
    .flush(flush), .out_valid(out_valid), .next_allow_in(next_allow_in), .out_data(out_data),
    .out_rd(out_rd), .out_wen(out_wen), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]  data;
    logic [RF_AW-1:0] rd;
    logic             wen;
    logic             chk;
    logic [XLEN-1:0]  hi;
    logic [XLEN-1:0]  lo;
  } exp_t;

  exp_t            sbq[$];
  exp_t            mon_e;
  logic [XLEN-1:0] m_hi = '0;
  logic [XLEN-1:0] m_lo = '0;
  int              checks = 0;
  int              errors = 0;

  always @(negedge clk) begin
    if (resetn && out_valid && next_allow_in) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: output with rd=%0d but nothing pending", out_rd);
      end else begin
        mon_e = sbq.pop_front();
        if (out_data !== mon_e.data) begin
          errors++;
          $display("FAIL sb_data: got %h expected %h", out_data, mon_e.data);
        end
        checks++;
        if (out_rd !== mon_e.rd) begin
          errors++;
          $display("FAIL sb_rd: got %0d expected %0d", out_rd, mon_e.rd);
        end
        checks++;
        if (out_wen !== mon_e.wen) begin
          errors++;
          $display("FAIL sb_wen: got %b expected %b", out_wen, mon_e.wen);
        end
        if (mon_e.chk) begin
          checks++;
          if (hi !== mon_e.hi || lo !== mon_e.lo) begin
            errors++;
            $display("FAIL sb_hilo: got %h_%h expected %h_%h", hi, lo, mon_e.hi, mon_e.lo);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1. Returns at posedge+1 just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic sel, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [RF_AW-1:0] rd, output int waited);
    exp_t e;
    logic signed [2*XLEN-1:0] sp;
    logic [2*XLEN-1:0] up;
    in_valid = 1'b1; in_op = op; in_sel_lo = sel; in_src_a = a; in_src_b = b; in_rd = rd;
    waited = 0;
    @(negedge clk);
    while (!allow_in && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    checks++;
    if (waited >= 200) begin
      errors++;
      $display("FAIL issue_timeout: allow_in stuck at %b, required 1", allow_in);
    end
    e.data = '0; e.rd = rd; e.wen = 1'b0; e.chk = 1'b0;
    case (op)
      3'd1: begin
        sp = $signed({{XLEN{a[XLEN-1]}}, a}) * $signed({{XLEN{b[XLEN-1]}}, b});
        {m_hi, m_lo} = sp;
        e.chk = 1'b1;
      end
      3'd2: begin
        up = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        {m_hi, m_lo} = up;
        e.chk = 1'b1;
      end
      3'd3: begin
        if (b == '0) begin
          m_lo = '1; m_hi = a;
        end else if (a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
          m_lo = a; m_hi = '0;
        end else begin
          m_lo = $signed(a) / $signed(b);
          m_hi = $signed(a) % $signed(b);
        end
        e.chk = 1'b1;
      end
      3'd4: begin
        if (b == '0) begin
          m_lo = '1; m_hi = a;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
        e.chk = 1'b1;
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      3'd7: begin
        e.data = sel ? m_lo : m_hi;
        e.wen  = 1'b1;
      end
      default: ;
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
    sbq.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", sbq.size());
    end
    step();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({out_valid, busy, out_wen, allow_in} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0001", {out_valid, busy, out_wen, allow_in});
    end
    checks++;
    if (hi !== '0 || lo !== '0 || out_data !== '0 || out_rd !== '0) begin
      errors++;
      $display("FAIL reset_data: got hi=%h lo=%h data=%h rd=%0d expected all 0",
               hi, lo, out_data, out_rd);
    end
    step();
  endtask

  task automatic test_mul();
    int w, lat;
    issue(3'd1, 1'b0, 32'hFFFF_FFFE, 32'd3, 5'd1, w);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != MulLat) begin
      errors++;
      $display("FAIL mul_latency: got %0d expected %0d", lat, MulLat);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_neg2x3: got %h_%h expected ffffffff_fffffffa", hi, lo);
    end
    step();
    issue(3'd7, 1'b1, '0, '0, 5'd2, w);
    issue(3'd2, 1'b0, 32'h8000_0001, 32'hFFFF_0003, 5'd3, w);
    issue(3'd7, 1'b0, '0, '0, 5'd4, w);
    wait_drain();
  endtask

  task automatic test_div();
    int w, n, bc;
    issue(3'd3, 1'b0, 32'hFFFF_FFF9, 32'd2, 5'd5, w);
    wait_drain();
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_neg7_2: got hi=%h lo=%h expected ffffffff fffffffd", hi, lo);
    end
    issue(3'd4, 1'b0, 32'd7, 32'd0, 5'd6, w);
    wait_drain();
    checks++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'd7) begin
      errors++;
      $display("FAIL divu_by_zero: got hi=%h lo=%h expected 00000007 ffffffff", hi, lo);
    end
    issue(3'd3, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, w);
    n = 0; bc = 0;
    while ((sbq.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
    end
    // Iteration cycles plus the single DONE cycle when the next stage is ready.
    checks++;
    if (bc != XLEN + 1) begin
      errors++;
      $display("FAIL div_busy_cycles: got %0d expected %0d", bc, XLEN + 1);
    end
    checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      errors++;
      $display("FAIL div_overflow: got hi=%h lo=%h expected 00000000 80000000", hi, lo);
    end
    step();
    issue(3'd3, 1'b0, 32'hFFFF_FFF0, 32'd0, 5'd8, w);
    issue(3'd7, 1'b0, '0, '0, 5'd9, w);
    issue(3'd7, 1'b1, '0, '0, 5'd10, w);
    wait_drain();
  endtask

  task automatic test_hold();
    int w, n;
    issue(3'd1, 1'b0, 32'h1234_5678, 32'hFFFF_FFFD, 5'd11, w);
    next_allow_in = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, allow_in, busy} !== 3'b101) begin
        errors++;
        $display("FAIL hold_ctrl[%0d]: got valid/allow/busy=%b expected 101", i,
                 {out_valid, allow_in, busy});
      end
      checks++;
      if (hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL hold_hilo[%0d]: got %h_%h expected %h_%h", i, hi, lo, m_hi, m_lo);
      end
      @(negedge clk);
    end
    step();
    next_allow_in = 1'b1;
    issue(3'd5, 1'b0, 32'h0000_1234, '0, 5'd12, w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL hold_release_accept: got %0d wait cycles expected 0", w);
    end
    issue(3'd7, 1'b0, '0, '0, 5'd13, w);
    wait_drain();
    checks++;
    if (hi !== 32'h0000_1234) begin
      errors++;
      $display("FAIL mthi_value: got %h expected 00001234", hi);
    end
  endtask

  task automatic test_flush();
    int w;
    logic [XLEN-1:0] sh, sl;
    sh = m_hi; sl = m_lo;
    issue(3'd4, 1'b0, 32'h0001_0000, 32'd7, 5'd14, w);
    repeat (8) step();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre_busy: got %b expected 1", busy);
    end
    step();
    flush = 1'b1; in_valid = 1'b1; in_op = 3'd6; in_src_a = 32'h0000_DEAD; in_rd = 5'd15;
    step();
    flush = 1'b0; in_valid = 1'b0;
    void'(sbq.pop_back());
    m_hi = sh; m_lo = sl;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, allow_in} !== 3'b001) begin
      errors++;
      $display("FAIL flush_ctrl: got valid/busy/allow=%b expected 001",
               {out_valid, busy, allow_in});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (hi !== sh || lo !== sl) begin
      errors++;
      $display("FAIL flush_hilo: got %h_%h expected %h_%h", hi, lo, sh, sl);
    end
    step();
  endtask

  task automatic test_async_reset();
    int w;
    issue(3'd4, 1'b0, 32'h0000_5555, 32'd3, 5'd16, w);
    repeat (3) step();
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, out_wen, allow_in} !== 4'b0001) begin
      errors++;
      $display("FAIL areset_ctrl: got %b expected 0001", {out_valid, busy, out_wen, allow_in});
    end
    checks++;
    if (hi !== '0 || lo !== '0 || out_data !== '0 || out_rd !== '0) begin
      errors++;
      $display("FAIL areset_data: got hi=%h lo=%h data=%h rd=%0d expected all 0",
               hi, lo, out_data, out_rd);
    end
    sbq.delete();
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    int w;
    issue(3'd6, 1'b0, 32'h0000_A5A5, '0, 5'd17, w);
    issue(3'd5, 1'b0, 32'h0000_5A5A, '0, 5'd18, w);
    issue(3'd7, 1'b1, '0, '0, 5'd19, w);
    issue(3'd7, 1'b0, '0, '0, 5'd20, w);
    issue(3'd0, 1'b0, 32'hFFFF_FFFF, '0, 5'd21, w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL b2b_single_stall: got %0d wait cycles expected 0", w);
    end
    issue(3'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd22, w);
    issue(3'd7, 1'b0, '0, '0, 5'd23, w);
    checks++;
    if (w != MulLat - 1) begin
      errors++;
      $display("FAIL b2b_after_mul: got %0d wait cycles expected %0d", w, MulLat - 1);
    end
    wait_drain();
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errors++;
      $display("FAIL multu_max: got %h_%h expected fffffffe_00000001", hi, lo);
    end
  endtask

  task automatic test_random_md();
    int w;
    logic [2:0] op;
    logic [XLEN-1:0] a, b;
    for (int i = 0; i < 6; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = $urandom;
      b  = (i % 2 == 0) ? $urandom : XLEN'($urandom_range(0, 9)) - XLEN'(4);
      issue(op, 1'b0, a, b, 5'(i + 24), w);
      issue(3'd7, 1'b0, '0, '0, 5'd30, w);
      issue(3'd7, 1'b1, '0, '0, 5'd31, w);
    end
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    step();
    test_reset();
    test_mul();
    test_div();
    test_hold();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random_md();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
